// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clk_div_gen PHY clock-tree divider.
//   DIV_FIELD_W       width of one packed log2-divide field
//   DIV_LOG2_DEFAULT  out0=/8 (4f), out1=/16 (2f), out2=/32 (f), out3=/2 (16f)
//   div_field()       extracts field i from a packed divide vector
//   div_cfg_ok()      legality check on the divider parameters
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int DIV_FIELD_W = 3;
  localparam logic [11:0] DIV_LOG2_DEFAULT = 12'o1543;

  function automatic int unsigned div_field(input logic [63:0] vec, input int unsigned i);
    logic [63:0] sh;
    sh = vec >> (i * DIV_FIELD_W);
    return 32'(sh[DIV_FIELD_W-1:0]);
  endfunction

  // Every field must select a ratio of at least /2 and no more than the
  // counter can produce.
  function automatic bit div_cfg_ok(input int num_out, input int max_log2,
                                    input logic [63:0] vec);
    if (num_out < 1 || max_log2 < 1) return 1'b0;
    for (int i = 0; i < num_out; i++) begin
      int f;
      f = int'(div_field(vec, i));
      if (f == 0 || f > max_log2) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/clk_div_lane.sv
// -----------------------------------------------------------------------------
// clk_div_lane
// One divided-clock output. Taps bit d-1 of the next counter value and gates
// it with a mask that only reloads on the output's own period boundary, so a
// mask change never shortens a high phase.
// Ports:
//   clk_32f   clock
//   reset     synchronous active-high reset
//   enable    counter advance qualifier (strobe build only)
//   cnt       current counter value (strobe build only)
//   cnt_next  counter value being loaded on this edge
//   d         log2 of the divide ratio
//   div_mask  run request; 0 gates the output low at the next boundary
//   div_rise  one-cycle rising-edge strobe (CLK_DIV_STROBE_EN only)
//   clk_div   divided clock, registered
// Optional feature macro: CLK_DIV_STROBE_EN
// -----------------------------------------------------------------------------
module clk_div_lane
  import clk_div_pkg::*;
#(
  parameter int W = 5
) (
  input  logic                   clk_32f,
  input  logic                   reset,
`ifdef CLK_DIV_STROBE_EN
  input  logic                   enable,
  input  logic [W-1:0]           cnt,
`endif
  input  logic [W-1:0]           cnt_next,
  input  logic [DIV_FIELD_W-1:0] d,
  input  logic                   div_mask,
`ifdef CLK_DIV_STROBE_EN
  output logic                   div_rise,
`endif
  output logic                   clk_div
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [IW-1:0] bit_idx;
  logic [W-1:0]  lo_mask;
  logic          boundary;
  logic          mask_eff;

  assign bit_idx  = IW'(d - 1'b1);
  assign lo_mask  = ~({W{1'b1}} << d);
  // Phase zero of this output: the tapped bit is low here, so loading the
  // mask now cannot cut a high phase short.
  assign boundary = (cnt_next & lo_mask) == '0;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values; the mask resets to ones so outputs run out of reset.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      mask_eff <= 1'b1;
      clk_div  <= 1'b0;
    end else begin
      clk_div <= cnt_next[bit_idx] & mask_eff;
      if (boundary) mask_eff <= div_mask;
    end
  end

`ifdef CLK_DIV_STROBE_EN
  always_ff @(posedge clk_32f) begin
    if (reset) div_rise <= 1'b0;
    else       div_rise <= cnt_next[bit_idx] & ~cnt[bit_idx] & mask_eff & enable;
  end
`endif

endmodule

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
// Power-of-two clock-divider generator for the PHY clock tree. One free-running
// counter clocked by clk_32f feeds NUM_OUT lanes, each tapping its own bit.
// Parameters:
//   NUM_OUT   number of divided outputs
//   MAX_LOG2  counter width; largest ratio is 2^MAX_LOG2
//   DIV_LOG2  packed 3-bit log2 ratios, field i drives output i
// Ports:
//   clk_32f   sole clock, rising edge
//   reset     synchronous active-high reset
//   enable    counter advances only when high
//   resync    one-cycle pulse realigning all outputs to phase zero
//   div_mask  per-output run request
//   clk_div   divided clocks, registered
//   div_rise  rising-edge strobes (CLK_DIV_STROBE_EN only)
//   locked    high once a full counter period has elapsed since reset/resync
// Optional feature macro: CLK_DIV_STROBE_EN
// -----------------------------------------------------------------------------
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_OUT  = 4,
  parameter int MAX_LOG2 = 5,
  parameter logic [DIV_FIELD_W*NUM_OUT-1:0] DIV_LOG2 = DIV_LOG2_DEFAULT
) (
  input  logic               clk_32f,
  input  logic               reset,
  input  logic               enable,
  input  logic               resync,
  input  logic [NUM_OUT-1:0] div_mask,
  output logic [NUM_OUT-1:0] clk_div,
`ifdef CLK_DIV_STROBE_EN
  output logic [NUM_OUT-1:0] div_rise,
`endif
  output logic               locked
);

  if (!div_cfg_ok(NUM_OUT, MAX_LOG2, 64'(DIV_LOG2))) begin : g_bad_cfg
    $error("clk_div_gen: illegal NUM_OUT/MAX_LOG2/DIV_LOG2 configuration");
  end

  logic [MAX_LOG2-1:0] cnt;
  logic [MAX_LOG2-1:0] cnt_next;

  // NOTE: cnt_next gets its default first so no path through this block
  // leaves it unassigned and infers a latch.
  always_comb begin
    cnt_next = cnt;
    if (reset || resync) cnt_next = '0;
    else if (enable)     cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

  // Sets on the wrap edge, so it marks one full period of the slowest ratio.
  always_ff @(posedge clk_32f) begin
    if (reset || resync)        locked <= 1'b0;
    else if (enable && cnt == '1) locked <= 1'b1;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    clk_div_lane #(
      .W (MAX_LOG2)
    ) u_lane (
      .clk_32f  (clk_32f),
      .reset    (reset),
`ifdef CLK_DIV_STROBE_EN
      .enable   (enable),
      .cnt      (cnt),
`endif
      .cnt_next (cnt_next),
      .d        (DIV_FIELD_W'(div_field(64'(DIV_LOG2), i))),
      .div_mask (div_mask[i]),
`ifdef CLK_DIV_STROBE_EN
      .div_rise (div_rise[i]),
`endif
      .clk_div  (clk_div[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
// Self-checking bench for clk_div_gen with default parameters. A cycle-level
// reference model counts edges with plain arithmetic and derives each output
// from the current phase within its period.
// Optional feature macro: CLK_DIV_STROBE_EN
// -----------------------------------------------------------------------------
module tb_clk_div_gen;

  localparam int N      = 4;
  localparam int PERIOD = 32;

  int div_log2_tb [N] = '{3, 4, 5, 1};

  logic         clk_32f  = 1'b0;
  logic         reset    = 1'b1;
  logic         enable   = 1'b0;
  logic         resync   = 1'b0;
  logic [N-1:0] div_mask = '1;
  logic [N-1:0] clk_div;
  logic         locked;
`ifdef CLK_DIV_STROBE_EN
  logic [N-1:0] div_rise;
`endif

  clk_div_gen dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .enable   (enable),
    .resync   (resync),
    .div_mask (div_mask),
    .clk_div  (clk_div),
`ifdef CLK_DIV_STROBE_EN
    .div_rise (div_rise),
`endif
    .locked   (locked)
  );

  always #5 clk_32f = ~clk_32f;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_cnt    = 0;
  bit           m_locked = 1'b0;
  bit [N-1:0]   m_mask   = '1;
  bit [N-1:0]   m_div    = '0;
`ifdef CLK_DIV_STROBE_EN
  bit [N-1:0]   m_rise   = '0;
`endif

  // Apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic tick(input bit en, input bit rst, input bit rsy, input logic [N-1:0] msk);
    int  nxt;
    int  p;
    bit  ph_n;
    bit  ph_o;
    enable   = en;
    reset    = rst;
    resync   = rsy;
    div_mask = msk;
    if (rst) begin
      m_cnt    = 0;
      m_locked = 1'b0;
      m_mask   = '1;
      m_div    = '0;
`ifdef CLK_DIV_STROBE_EN
      m_rise   = '0;
`endif
    end else begin
      if (rsy)     nxt = 0;
      else if (en) nxt = (m_cnt + 1) % PERIOD;
      else         nxt = m_cnt;
      if (rsy) m_locked = 1'b0;
      else if (en && m_cnt == PERIOD - 1) m_locked = 1'b1;
      for (int i = 0; i < N; i++) begin
        p    = 1 << div_log2_tb[i];
        ph_n = (nxt % p) >= p / 2;
        ph_o = (m_cnt % p) >= p / 2;
        m_div[i] = ph_n && m_mask[i];
`ifdef CLK_DIV_STROBE_EN
        m_rise[i] = ph_n && !ph_o && m_mask[i] && en;
`else
        if (ph_o && !ph_n) p = p; // phase history only matters for the strobe
`endif
        if (nxt % p == 0) m_mask[i] = msk[i];
      end
      m_cnt = nxt;
    end
    @(posedge clk_32f);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, '1);
    checks++;
    if ({clk_div, locked} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: clk_div=%b locked=%b, expected 0000/0", clk_div, locked);
    end
`ifdef CLK_DIV_STROBE_EN
    checks++;
    if (div_rise !== '0) begin
      errors++;
      $display("FAIL reset_strobe: div_rise=%b, expected 0000", div_rise);
    end
`endif
  endtask

  task automatic test_divide();
    for (int k = 1; k <= 40; k++) begin
      tick(1'b1, 1'b0, 1'b0, '1);
      checks++;
      if ({clk_div, locked} !== {m_div, m_locked}) begin
        errors++;
        $display("FAIL divide_model edge %0d: got %b/%b, expected %b/%b", k, clk_div, locked, m_div, m_locked);
      end
      checks++;
      if (clk_div[3] !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL div2_toggle edge %0d: got %b", k, clk_div[3]);
      end
      if (k <= 16) begin
        checks++;
        if (clk_div[0] !== ((k % 8) >= 4)) begin
          errors++;
          $display("FAIL div8_phase edge %0d: got %b, expected %b", k, clk_div[0], (k % 8) >= 4);
        end
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (clk_div[2] !== (k == 16)) begin
          errors++;
          $display("FAIL div32_first_rise edge %0d: got %b", k, clk_div[2]);
        end
      end
      if (k == 31 || k == 32) begin
        checks++;
        if (locked !== (k == 32)) begin
          errors++;
          $display("FAIL locked_rise edge %0d: got %b", k, locked);
        end
      end
    end
  endtask

  task automatic test_freeze();
    for (int g = 0; g < 64 && m_cnt != 5; g++) tick(1'b1, 1'b0, 1'b0, '1);
    checks++;
    if (clk_div !== 4'b1001) begin
      errors++;
      $display("FAIL freeze_entry: clk_div=%b, expected 1001", clk_div);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 1'b0, '1);
      checks++;
      if ({clk_div, locked} !== {4'b1001, 1'b1}) begin
        errors++;
        $display("FAIL freeze_hold cycle %0d: got %b/%b, expected 1001/1", k, clk_div, locked);
      end
    end
    tick(1'b1, 1'b0, 1'b0, '1);
    checks++;
    if ({clk_div, locked} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL freeze_resume: got %b/%b, expected 0001/1 (cnt=6)", clk_div, locked);
    end
  endtask

  task automatic test_resync();
    for (int g = 0; g < 64 && m_cnt != 20; g++) tick(1'b1, 1'b0, 1'b0, '1);
    tick(1'b1, 1'b0, 1'b1, '1);
    checks++;
    if ({clk_div, locked} !== 5'b0) begin
      errors++;
      $display("FAIL resync_clear: got %b/%b, expected 0000/0", clk_div, locked);
    end
    for (int n = 1; n <= 34; n++) begin
      tick(1'b1, 1'b0, 1'b0, '1);
      checks++;
      if ({clk_div, locked} !== {m_div, m_locked}) begin
        errors++;
        $display("FAIL resync_model edge %0d: got %b/%b, expected %b/%b", n, clk_div, locked, m_div, m_locked);
      end
      checks++;
      if (locked !== (n >= 32)) begin
        errors++;
        $display("FAIL resync_relock edge %0d: got %b", n, locked);
      end
    end
  endtask

  task automatic test_mask();
    for (int g = 0; g < 64 && m_cnt != 10; g++) tick(1'b1, 1'b0, 1'b0, '1);
    checks++;
    if (clk_div[1] !== 1'b1) begin
      errors++;
      $display("FAIL mask_start: clk_div[1]=%b, expected 1", clk_div[1]);
    end
    for (int g = 0; g < 64 && m_cnt != 20; g++) begin
      tick(1'b1, 1'b0, 1'b0, 4'b1101);
      checks++;
      if (clk_div[1] !== (m_cnt < 16)) begin
        errors++;
        $display("FAIL mask_gate cnt %0d: clk_div[1]=%b, expected %b", m_cnt, clk_div[1], m_cnt < 16);
      end
      checks++;
      if (clk_div !== m_div) begin
        errors++;
        $display("FAIL mask_model cnt %0d: got %b, expected %b", m_cnt, clk_div, m_div);
      end
    end
    for (int g = 0; g < 64; g++) begin
      tick(1'b1, 1'b0, 1'b0, '1);
      checks++;
      if (clk_div[1] !== (m_cnt == 8)) begin
        errors++;
        $display("FAIL mask_reenable cnt %0d: clk_div[1]=%b, expected %b", m_cnt, clk_div[1], m_cnt == 8);
      end
      if (m_cnt == 8) break;
    end
  endtask

  task automatic test_all_high();
    for (int g = 0; g < 32; g++) tick(1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (clk_div !== 4'b0000) begin
      errors++;
      $display("FAIL all_masked: clk_div=%b, expected 0000", clk_div);
    end
    tick(1'b1, 1'b1, 1'b1, 4'b0000);
    checks++;
    if ({clk_div, locked} !== 5'b0) begin
      errors++;
      $display("FAIL all_high_reset: got %b/%b, expected 0000/0", clk_div, locked);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b0, 1'b0, 4'b0000);
      checks++;
      if (clk_div[0] !== (k >= 4 && k < 8) || clk_div[3] !== (k == 1)) begin
        errors++;
        $display("FAIL mask_reload_ones edge %0d: clk_div=%b", k, clk_div);
      end
      checks++;
      if ({clk_div, locked} !== {m_div, m_locked}) begin
        errors++;
        $display("FAIL all_high_model edge %0d: got %b/%b, expected %b/%b", k, clk_div, locked, m_div, m_locked);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] msk;
    bit en;
    bit rst;
    bit rsy;
    msk = '1;
    for (int k = 0; k < 400; k++) begin
      en  = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 49) == 0;
      rsy = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 7) == 0) msk = N'($urandom);
      tick(en, rst, rsy, msk);
      checks++;
      if ({clk_div, locked} !== {m_div, m_locked}) begin
        errors++;
        $display("FAIL random_model step %0d: got %b/%b, expected %b/%b", k, clk_div, locked, m_div, m_locked);
      end
`ifdef CLK_DIV_STROBE_EN
      checks++;
      if (div_rise !== m_rise) begin
        errors++;
        $display("FAIL random_strobe step %0d: got %b, expected %b", k, div_rise, m_rise);
      end
`endif
    end
  endtask

`ifdef CLK_DIV_STROBE_EN
  task automatic test_strobe();
    tick(1'b0, 1'b1, 1'b0, '1);
    for (int k = 1; k <= 24; k++) begin
      tick(1'b1, 1'b0, 1'b0, '1);
      checks++;
      if (div_rise[0] !== (k == 4 || k == 12 || k == 20)) begin
        errors++;
        $display("FAIL strobe_div8 edge %0d: got %b", k, div_rise[0]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, 1'b0, '1);
      checks++;
      if (div_rise !== '0) begin
        errors++;
        $display("FAIL strobe_disabled cycle %0d: got %b", k, div_rise);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divide();
    test_freeze();
    test_resync();
    test_mask();
    test_all_high();
`ifdef CLK_DIV_STROBE_EN
    test_strobe();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
